pps_period_counter: RTL and testbench
=====================================

PPS_PERIOD_COUNTER -- requirements
Module: pps_period_counter

Interface
REQ-001 SHALL have parameter NOMINAL, 10000000, expected CLOCK_10M cycles per PPS period.
REQ-002 SHALL have parameter MIN_PERIOD, 9500000, shortest accepted period; shorter edges are glitches.
REQ-003 SHALL have parameter TIMEOUT, 10500000, longest accepted period; also the loss-of-PPS limit.
REQ-004 SHALL have parameter TOL, 100, maximum |ERROR| that counts as a good period.
REQ-005 SHALL have parameter GOOD_N, 4, number of consecutive good periods needed to assert LOCKED.
REQ-006 SHALL have port CLOCK_10M, in, 1, the single clock; one clock, no other clock domains.
REQ-007 SHALL have port RESET, in, 1, asynchronous active-high reset.
REQ-008 SHALL have port GPS_PPS, in, 1, raw asynchronous GPS 1PPS pin.
REQ-009 SHALL have port GPS_LOCK, in, 1, GPS receiver fix indicator, synchronous to CLOCK_10M.
REQ-010 SHALL have port COUNT, out, 32, last accepted period in cycles.
REQ-011 SHALL have port ERROR, out, 24, signed COUNT minus NOMINAL.
REQ-012 SHALL have port VALID, out, 1, one-cycle strobe when COUNT and ERROR update.
REQ-013 SHALL have port LOCKED, out, 1, GOOD_N consecutive good periods seen.
REQ-014 SHALL have port PPS_LOST, out, 1, sticky flag for a timeout without a PPS edge.

Function
REQ-015 SHALL pass GPS_PPS through a 2-flop synchronizer and a rising-edge detector: 1-cycle EDGE pulse, 3 cycles after the pin rises.
REQ-016 SHALL implement the FSM IDLE -> ARM -> MEASURE:
- IDLE: leave only when GPS_LOCK=1.
- ARM: on EDGE, go to MEASURE with cnt=0.
- MEASURE: counting.
- Any state: GPS_LOCK=0 forces IDLE.
REQ-017 In MEASURE, cnt SHALL increment by 1 per cycle, so with EDGE pulses N cycles apart the measured period meas=cnt+1 equals N.
REQ-018 On EDGE in MEASURE with MIN_PERIOD<=meas<=TIMEOUT, the block SHALL, on the next clock edge:
- load COUNT=meas and ERROR=meas-NOMINAL;
- pulse VALID for one cycle;
- clear PPS_LOST;
- restart cnt at 0.
REQ-019 On EDGE in MEASURE with meas<MIN_PERIOD, the edge SHALL be discarded as a glitch: no VALID, cnt keeps counting, good-run counter cleared.
REQ-020 In MEASURE, if cnt reaches TIMEOUT without EDGE, the block SHALL set PPS_LOST=1, clear LOCKED and the good-run counter, and return to ARM.
REQ-021 If EDGE and the timeout condition occur in the same cycle, the EDGE SHALL win (meas=TIMEOUT, accepted).
REQ-022 Good-run counter (saturating at GOOD_N):
- accepted period with |ERROR|<=TOL: increment;
- accepted period with |ERROR|>TOL: clear and drop LOCKED;
- LOCKED asserts in the VALID cycle that brings the count to GOOD_N.
REQ-023 On entry to IDLE the block SHALL clear LOCKED and the good-run counter; COUNT, ERROR and PPS_LOST hold their values.
REQ-024 ERROR SHALL be computed at 32 bits and truncated to 24 bits; truncation is lossless because accepted meas is bounded by MIN_PERIOD and TIMEOUT.

Reset
REQ-025 RESET=1 SHALL asynchronously force state=IDLE, cnt=0, synchronizer flops=0, COUNT=0, ERROR=0, VALID=0, LOCKED=0, PPS_LOST=0.
REQ-026 Reset deassertion mid-operation SHALL restart measurement from IDLE; no partial period is reported.
REQ-027 A PPS edge already high at reset release SHALL NOT generate EDGE.

Structure
REQ-028 Package pps_counter_pkg SHALL hold the FSM state encoding (IDLE, ARM, MEASURE) and the default values of NOMINAL, MIN_PERIOD, TIMEOUT, TOL and GOOD_N.
REQ-029 The synchronizer and edge detector SHALL be sub-module pps_sync_edge (ports CLOCK_10M, RESET, ASYNC_IN, EDGE).

Verification (bench parameters: NOMINAL=1000, MIN_PERIOD=950, TIMEOUT=1050, TOL=2, GOOD_N=4)
REQ-030 GPS_LOCK=1 with PPS every 1000 cycles -> first VALID on the 2nd edge with COUNT=1000 and ERROR=0; LOCKED=1 at the 4th VALID.
REQ-031 PPS periods 1000, 1003, 1000 -> ERROR=+3 on the 2nd, good-run counter cleared and LOCKED=0; LOCKED reasserts only after 4 further good periods.
REQ-032 Extra PPS pulse 400 cycles after an edge, next edge at 1000 -> no VALID for the glitch; next VALID has COUNT=1000.
REQ-033 PPS stopped -> PPS_LOST=1 exactly 1050 cycles after the last EDGE and LOCKED=0; PPS resumed -> first accepted period clears PPS_LOST.
REQ-034 Edge exactly 1050 cycles apart -> COUNT=1050, ERROR=+50, PPS_LOST stays 0; GPS_LOCK dropped mid-period -> no VALID, LOCKED=0.
REQ-035 RESET pulsed mid-period -> all outputs 0 asynchronously; measuring restarts with ARM on the next edge after GPS_LOCK=1.

Source files
------------

// File: rtl/pps_counter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pps_counter_pkg
// Description : Shared constants for the GPS 1PPS period counter: FSM state
//               encoding, default timing parameters and a tolerance helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pps_counter_pkg;

    // Measurement FSM state encoding
    localparam int         c_STATE_W    = 2;
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARM     = 2'd1;
    localparam logic [1:0] c_ST_MEASURE = 2'd2;

    // Output widths
    localparam int c_CNT_W = 32;
    localparam int c_ERR_W = 24;

    // Default timing for a 10 MHz reference against a 1 Hz PPS
    localparam int c_NOMINAL_DEFAULT    = 10_000_000;
    localparam int c_MIN_PERIOD_DEFAULT = 9_500_000;
    localparam int c_TIMEOUT_DEFAULT    = 10_500_000;
    localparam int c_TOL_DEFAULT        = 100;
    localparam int c_GOOD_N_DEFAULT     = 4;

    // True when a signed period error lies within +/- tol
    function automatic logic f_within_tol(input logic signed [31:0] err, input int tol);
        return (err <= tol) && (err >= -tol);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pps_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pps_sync_edge
// Description : Two-flop synchronizer plus registered rising-edge detector for
//               the raw GPS 1PPS pin. EDGE is a one-cycle pulse that appears
//               three clocks after the pin rises.
// Revision    : 1.0 - initial release
// ============================================================================
module pps_sync_edge (
    input  logic CLOCK_10M,
    input  logic RESET,
    input  logic ASYNC_IN,
    output logic EDGE
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [1:0] r_warm;
    logic       r_edge;

    // Synchronize the pin and flag a 0->1 transition. r_prev is held high
    // until the synchronizer holds real pin samples, so a pin that is already
    // high when reset releases never looks like a fresh rising edge.
    always_ff @(posedge CLOCK_10M or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b1;
            r_warm  <= 2'b00;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= ASYNC_IN;
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
            r_prev  <= r_warm[1] ? r_sync2 : 1'b1;
            r_edge  <= r_sync2 & ~r_prev;
        end
    end

    assign EDGE = r_edge;

endmodule
`default_nettype wire

// File: rtl/pps_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : pps_period_counter
// Description : Measures the GPS 1PPS period in CLOCK_10M cycles, reports the
//               signed deviation from nominal, rejects glitch edges, detects
//               loss of PPS and declares lock after a run of good periods.
// Revision    : 1.0 - initial release
// ============================================================================
module pps_period_counter
    import pps_counter_pkg::*;
#(
    parameter int NOMINAL    = c_NOMINAL_DEFAULT,
    parameter int MIN_PERIOD = c_MIN_PERIOD_DEFAULT,
    parameter int TIMEOUT    = c_TIMEOUT_DEFAULT,
    parameter int TOL        = c_TOL_DEFAULT,
    parameter int GOOD_N     = c_GOOD_N_DEFAULT
) (
    input  logic               CLOCK_10M,
    input  logic               RESET,
    input  logic               GPS_PPS,
    input  logic               GPS_LOCK,
    output logic [c_CNT_W-1:0] COUNT,
    output logic [c_ERR_W-1:0] ERROR,
    output logic               VALID,
    output logic               LOCKED,
    output logic               PPS_LOST
);

    localparam logic [c_CNT_W-1:0] c_NOMINAL    = c_CNT_W'(NOMINAL);
    localparam logic [c_CNT_W-1:0] c_MIN_PERIOD = c_CNT_W'(MIN_PERIOD);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(TIMEOUT);
    localparam int                 c_GOOD_W     = $clog2(GOOD_N + 1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_N    = c_GOOD_W'(GOOD_N);

    logic                        w_edge;
    logic [c_STATE_W-1:0]        r_state;
    logic [c_STATE_W-1:0]        w_state_next;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_CNT_W-1:0]          w_meas;
    logic signed [c_CNT_W-1:0]   w_err32;
    logic                        w_good_period;
    logic                        w_accept;
    logic                        w_glitch;
    logic                        w_timeout;
    logic [c_GOOD_W-1:0]         r_good;
    logic [c_GOOD_W-1:0]         w_good_inc;
    logic [c_CNT_W-1:0]          r_count;
    logic [c_ERR_W-1:0]          r_error;
    logic                        r_valid;
    logic                        r_locked;
    logic                        r_pps_lost;

    pps_sync_edge u_sync_edge (
        .CLOCK_10M (CLOCK_10M),
        .RESET     (RESET),
        .ASYNC_IN  (GPS_PPS),
        .EDGE      (w_edge)
    );

    // The edge cycle itself counts toward the period, hence the +1
    assign w_meas        = r_cnt + 1'b1;
    assign w_err32       = $signed(w_meas - c_NOMINAL);
    assign w_good_period = f_within_tol(w_err32, TOL);
    assign w_good_inc    = (r_good >= c_GOOD_N) ? c_GOOD_N : r_good + 1'b1;

    // FSM state register
    always_ff @(posedge CLOCK_10M or posedge RESET) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-edge classification; an edge landing on the timeout
    // cycle is accepted because the accept branch is tested first
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_glitch     = 1'b0;
        w_timeout    = 1'b0;
        if (!GPS_LOCK) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_next = c_ST_ARM;
                end
                c_ST_ARM: begin
                    if (w_edge) begin
                        w_state_next = c_ST_MEASURE;
                    end
                end
                c_ST_MEASURE: begin
                    if (w_edge && (w_meas >= c_MIN_PERIOD) && (w_meas <= c_TIMEOUT)) begin
                        w_accept = 1'b1;
                    end else if (w_edge && (w_meas < c_MIN_PERIOD)) begin
                        w_glitch = 1'b1;
                    end else if (w_meas >= c_TIMEOUT) begin
                        w_timeout    = 1'b1;
                        w_state_next = c_ST_ARM;
                    end
                end
                default: begin
                    w_state_next = c_ST_IDLE;
                end
            endcase
        end
    end

    // Period counter: runs only while staying in MEASURE, restarts on accept
    always_ff @(posedge CLOCK_10M or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if ((r_state == c_ST_MEASURE) && (w_state_next == c_ST_MEASURE) && !w_accept) begin
            r_cnt <= w_meas;
        end else begin
            r_cnt <= '0;
        end
    end

    // Result registers and the VALID strobe for each accepted period
    always_ff @(posedge CLOCK_10M or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
            r_error <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_count <= w_meas;
                r_error <= w_err32[c_ERR_W-1:0];
            end
        end
    end

    // Lock qualification and loss-of-PPS tracking
    always_ff @(posedge CLOCK_10M or posedge RESET) begin
        if (RESET) begin
            r_good     <= '0;
            r_locked   <= 1'b0;
            r_pps_lost <= 1'b0;
        end else if (w_state_next == c_ST_IDLE) begin
            r_good   <= '0;
            r_locked <= 1'b0;
        end else if (w_accept) begin
            r_pps_lost <= 1'b0;
            if (w_good_period) begin
                r_good <= w_good_inc;
                if (w_good_inc == c_GOOD_N) begin
                    r_locked <= 1'b1;
                end
            end else begin
                r_good   <= '0;
                r_locked <= 1'b0;
            end
        end else if (w_glitch) begin
            r_good <= '0;
        end else if (w_timeout) begin
            r_good     <= '0;
            r_locked   <= 1'b0;
            r_pps_lost <= 1'b1;
        end
    end

    assign COUNT    = r_count;
    assign ERROR    = r_error;
    assign VALID    = r_valid;
    assign LOCKED   = r_locked;
    assign PPS_LOST = r_pps_lost;

endmodule
`default_nettype wire

// File: tb/tb_pps_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pps_period_counter
// Description : Directed self-checking bench for pps_period_counter using
//               scaled-down timing (1000-cycle nominal period).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pps_period_counter;

    localparam int c_NOMINAL    = 1000;
    localparam int c_MIN_PERIOD = 950;
    localparam int c_TIMEOUT    = 1050;
    localparam int c_TOL        = 2;
    localparam int c_GOOD_N     = 4;

    logic        CLOCK_10M = 1'b0;
    logic        RESET     = 1'b1;
    logic        GPS_PPS   = 1'b0;
    logic        GPS_LOCK  = 1'b0;
    logic [31:0] COUNT;
    logic [23:0] ERROR;
    logic        VALID;
    logic        LOCKED;
    logic        PPS_LOST;

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          valid_cnt = 0;
    logic [31:0] v_count   = '0;
    logic [23:0] v_error   = '0;

    always #5 CLOCK_10M = ~CLOCK_10M;

    pps_period_counter #(
        .NOMINAL    (c_NOMINAL),
        .MIN_PERIOD (c_MIN_PERIOD),
        .TIMEOUT    (c_TIMEOUT),
        .TOL        (c_TOL),
        .GOOD_N     (c_GOOD_N)
    ) dut (
        .CLOCK_10M (CLOCK_10M),
        .RESET     (RESET),
        .GPS_PPS   (GPS_PPS),
        .GPS_LOCK  (GPS_LOCK),
        .COUNT     (COUNT),
        .ERROR     (ERROR),
        .VALID     (VALID),
        .LOCKED    (LOCKED),
        .PPS_LOST  (PPS_LOST)
    );

    // Record every VALID cycle and the result it carried
    always @(negedge CLOCK_10M) begin
        if (VALID === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            v_count   = COUNT;
            v_error   = ERROR;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_valid(input string tag, input int exp_n,
                               input logic [31:0] exp_count, input logic [23:0] exp_err);
        check({tag, "_nvalid"}, valid_cnt, exp_n);
        check({tag, "_count"}, v_count, exp_count);
        check({tag, "_error"}, {8'h00, v_error}, {8'h00, exp_err});
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLOCK_10M);
    endtask

    // Raise the pin now, keep it high 5 cycles, return n cycles after the rise
    task automatic pps_period(input int n);
        GPS_PPS = 1'b1;
        wait_neg(5);
        GPS_PPS = 1'b0;
        wait_neg(n - 5);
    endtask

    initial begin
        // Reset with the pin already high: its release must not count as an edge
        RESET    = 1'b1;
        GPS_PPS  = 1'b1;
        GPS_LOCK = 1'b1;
        wait_neg(3);
        check("rst_count", COUNT, 32'd0);
        check("rst_error", {8'h00, ERROR}, 32'd0);
        check("rst_valid", {31'd0, VALID}, 32'd0);
        check("rst_locked", {31'd0, LOCKED}, 32'd0);
        check("rst_lost", {31'd0, PPS_LOST}, 32'd0);
        RESET = 1'b0;
        wait_neg(10);
        GPS_PPS = 1'b0;
        wait_neg(5);

        // Steady 1000-cycle PPS: first VALID on the 2nd edge, lock on the 4th VALID
        pps_period(1000);
        check("a_first_edge_nvalid", valid_cnt, 32'd0);
        pps_period(1000);
        check_valid("a_v1", 1, 32'd1000, 24'd0);
        check("a_v1_locked", {31'd0, LOCKED}, 32'd0);
        pps_period(1000);
        pps_period(1000);
        check("a_v3_nvalid", valid_cnt, 32'd3);
        check("a_v3_locked", {31'd0, LOCKED}, 32'd0);
        pps_period(1000);
        check_valid("a_v4", 4, 32'd1000, 24'd0);
        check("a_v4_locked", {31'd0, LOCKED}, 32'd1);

        // Periods 1000, 1003, 1000: the +3 period breaks lock
        pps_period(1003);
        check("b_v5_nvalid", valid_cnt, 32'd5);
        check("b_v5_locked", {31'd0, LOCKED}, 32'd1);
        pps_period(1000);
        check_valid("b_v6", 6, 32'd1003, 24'd3);
        check("b_v6_locked", {31'd0, LOCKED}, 32'd0);
        pps_period(1000);
        pps_period(1000);
        pps_period(1000);
        check("b_v9_nvalid", valid_cnt, 32'd9);
        check("b_v9_locked", {31'd0, LOCKED}, 32'd0);
        pps_period(1002);
        check("b_v10_locked", {31'd0, LOCKED}, 32'd1);
        // Errors of exactly +/-TOL are still good
        pps_period(998);
        check_valid("b_v11", 11, 32'd1002, 24'd2);
        check("b_v11_locked", {31'd0, LOCKED}, 32'd1);
        pps_period(1000);
        check_valid("b_v12", 12, 32'd998, 24'hFF_FFFE);
        check("b_v12_locked", {31'd0, LOCKED}, 32'd1);

        // Glitch pulse 400 cycles after an edge, real edge at 1000
        pps_period(400);
        check_valid("c_v13", 13, 32'd1000, 24'd0);
        pps_period(600);
        check("c_glitch_nvalid", valid_cnt, 32'd13);
        pps_period(1000);
        check_valid("c_v14", 14, 32'd1000, 24'd0);

        // PPS stops: PPS_LOST rises exactly where a VALID for a 1050-cycle
        // period would appear (4 clocks after a rise 1050 cycles on)
        wait_neg(53);
        check("d_lost_before", {31'd0, PPS_LOST}, 32'd0);
        wait_neg(1);
        check("d_lost_at", {31'd0, PPS_LOST}, 32'd1);
        check("d_lost_locked", {31'd0, LOCKED}, 32'd0);
        check("d_lost_nvalid", valid_cnt, 32'd14);
        pps_period(1000);
        check("d_rearm_lost", {31'd0, PPS_LOST}, 32'd1);
        check("d_rearm_nvalid", valid_cnt, 32'd14);
        pps_period(1000);
        check_valid("d_v15", 15, 32'd1000, 24'd0);
        check("d_v15_lost", {31'd0, PPS_LOST}, 32'd0);

        // Boundary periods: exactly TIMEOUT and exactly MIN_PERIOD are accepted
        pps_period(1050);
        check("e_v16_nvalid", valid_cnt, 32'd16);
        pps_period(1000);
        check_valid("e_v17", 17, 32'd1050, 24'd50);
        check("e_v17_lost", {31'd0, PPS_LOST}, 32'd0);
        pps_period(950);
        pps_period(1000);
        check_valid("e_v19", 19, 32'd950, 24'hFF_FFCE);
        pps_period(1000);
        pps_period(1000);
        pps_period(1000);
        pps_period(1000);
        check("e_v23_nvalid", valid_cnt, 32'd23);
        check("e_v23_locked", {31'd0, LOCKED}, 32'd1);

        // GPS_LOCK dropped mid-period: lock lost, no VALID from the next edge
        GPS_LOCK = 1'b0;
        wait_neg(10);
        check("e_nolock_locked", {31'd0, LOCKED}, 32'd0);
        pps_period(1000);
        check("e_nolock_nvalid", valid_cnt, 32'd23);
        check("e_nolock_lost", {31'd0, PPS_LOST}, 32'd0);

        // Reset pulsed mid-period: outputs clear without waiting for a clock
        GPS_LOCK = 1'b1;
        wait_neg(5);
        pps_period(1000);
        pps_period(500);
        check_valid("f_v24", 24, 32'd1000, 24'd0);
        #3;
        RESET = 1'b1;
        #1;
        check("f_async_count", COUNT, 32'd0);
        check("f_async_error", {8'h00, ERROR}, 32'd0);
        check("f_async_valid", {31'd0, VALID}, 32'd0);
        check("f_async_locked", {31'd0, LOCKED}, 32'd0);
        check("f_async_lost", {31'd0, PPS_LOST}, 32'd0);
        wait_neg(3);
        RESET = 1'b0;
        wait_neg(5);
        pps_period(1000);
        check("f_rearm_nvalid", valid_cnt, 32'd24);
        pps_period(1000);
        check_valid("f_v25", 25, 32'd1000, 24'd0);
        check("f_v25_locked", {31'd0, LOCKED}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
